tdm_demux4: RTL and testbench



---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_slot_ctr.sv | 40 ++++
 rtl/tdm_demux4.sv | 125 ++++++++++++
 tb/tb_tdm_demux4.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM receive path: channel count,
// slot index type and the lock FSM state encoding.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_ZERO = slot_t'(0);
    localparam slot_t SLOT_ONE  = slot_t'(1);
    localparam slot_t SLOT_LAST = slot_t'(NUM_CH - 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot position counter: clear has priority over load-to-1,
// which has priority over increment. tc_o flags the last slot of a frame.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  load1_i,
    input  logic  inc_i,
    output slot_t slot_o,
    output logic  tc_o
);

    slot_t slot_q;
    slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = SLOT_ZERO;
        end else if (load1_i) begin
            slot_d = SLOT_ONE;
        end else if (inc_i) begin
            slot_d = slot_q + SLOT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_ZERO;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign tc_o   = (slot_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux4.sv
// TDM 1:4 demultiplexer: locks onto sof-marked frames, fans slot words out to
// registered channel outputs and reports frame completion and framing errors.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FCNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    sof,
    output logic [NUM_CH*WIDTH-1:0] y,
    output logic [NUM_CH-1:0]       ch_valid,
    output logic                    frame_done,
    output logic                    sync_err,
    output logic                    locked,
    output logic [FCNT_W-1:0]       frame_cnt
);

    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    state_e                    state_q;
    state_e                    state_d;
    logic [NUM_CH*WIDTH-1:0]   y_q;
    logic [NUM_CH-1:0]         ch_valid_q;
    logic                      frame_done_q;
    logic                      sync_err_q;
    logic [FCNT_W-1:0]         frame_cnt_q;

    logic                      cap_en;
    slot_t                     cap_ch;
    logic                      frame_done_d;
    logic                      sync_err_d;
    logic                      slot_clr;
    logic                      slot_load1;
    logic                      slot_inc;
    slot_t                     slot;
    logic                      slot_tc;

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (slot_clr),
        .load1_i (slot_load1),
        .inc_i   (slot_inc),
        .slot_o  (slot),
        .tc_o    (slot_tc)
    );

    // Invalid cycles (sof included) fall through with every control at default.
    always_comb begin
        state_d      = state_q;
        cap_en       = 1'b0;
        cap_ch       = SLOT_ZERO;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        slot_clr     = 1'b0;
        slot_load1   = 1'b0;
        slot_inc     = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (sof) begin
                        cap_en     = 1'b1;
                        slot_load1 = 1'b1;
                        state_d    = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (sof) begin
                        cap_en     = 1'b1;
                        slot_load1 = 1'b1;
                        sync_err_d = (slot != SLOT_ZERO);
                    end else if (slot == SLOT_ZERO) begin
                        sync_err_d = 1'b1;
                        slot_clr   = 1'b1;
                        state_d    = ST_HUNT;
                    end else begin
                        cap_en       = 1'b1;
                        cap_ch       = slot;
                        slot_inc     = 1'b1;
                        frame_done_d = slot_tc;
                    end
                end
                default: begin
                    slot_clr = 1'b1;
                    state_d  = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            y_q          <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ch_valid_q   <= '0;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            if (cap_en) begin
                y_q[int'(cap_ch)*WIDTH +: WIDTH] <= din;
                ch_valid_q[cap_ch]               <= 1'b1;
            end
            if (frame_done_d) begin
                frame_cnt_q <= frame_cnt_q + FCNT_ONE;
            end
        end
    end

    assign y          = y_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == ST_LOCKED);
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and random stimulus for tdm_demux4 checked cycle by cycle against a
// frame-level reference model of channel contents, slot position and lock.
module tb_tdm_demux4;

    localparam int W  = 8;
    localparam int FW = 8;
    localparam int YW = 4 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          sof = 1'b0;
    logic [YW-1:0] y;
    logic [3:0]    ch_valid;
    logic          frame_done;
    logic          sync_err;
    logic          locked;
    logic [FW-1:0] frame_cnt;

    tdm_demux4 #(.WIDTH(W), .FCNT_W(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .y          (y),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: what each channel holds, where in the frame we are.
    logic [W-1:0]  m_ch [4];
    int            m_slot;
    bit            m_locked;
    int            m_fcnt;
    logic [3:0]    e_chv;
    bit            e_fd;
    bit            e_se;
    logic [YW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        e_chv = '0;
        e_fd  = 1'b0;
        e_se  = 1'b0;
        if (r) begin
            for (int k = 0; k < 4; k++) m_ch[k] = '0;
            m_slot   = 0;
            m_locked = 1'b0;
            m_fcnt   = 0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0]  = d;
                    e_chv    = 4'b0001;
                    m_slot   = 1;
                    m_locked = 1'b1;
                end
            end else if (s) begin
                e_se    = (m_slot != 0);
                m_ch[0] = d;
                e_chv   = 4'b0001;
                m_slot  = 1;
            end else if (m_slot == 0) begin
                e_se     = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_ch[m_slot] = d;
                e_chv        = 4'(1 << m_slot);
                if (m_slot == 3) begin
                    e_fd   = 1'b1;
                    m_fcnt = (m_fcnt + 1) % (1 << FW);
                end
                m_slot = (m_slot + 1) % 4;
            end
        end
        exp_q.push_back({m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        logic [YW-1:0] ey;
        @(negedge clk);
        rst       = r;
        din_valid = v;
        sof       = s;
        din       = d;
        model(r, v, s, d);
        @(posedge clk);
        #1;
        ey = exp_q.pop_front();
        chk("y", y, ey);
        chk("ch_valid", {28'd0, ch_valid}, {28'd0, e_chv});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        chk("sync_err", {31'd0, sync_err}, {31'd0, e_se});
        chk("locked", {31'd0, locked}, {31'd0, m_locked});
        chk("frame_cnt", {24'd0, frame_cnt}, 32'(m_fcnt));
    endtask

    task automatic frame(input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3);
        step(0, 1, 1, d0);
        step(0, 1, 0, d1);
        step(0, 1, 0, d2);
        step(0, 1, 0, d3);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("reset_y", y, 32'h0);
        chk("reset_locked", {31'd0, locked}, 32'd0);

        // Basic frame
        step(0, 1, 1, 8'h11);
        chk("first_lock", {31'd0, locked}, 32'd1);
        step(0, 1, 0, 8'h22);
        step(0, 1, 0, 8'h33);
        step(0, 1, 0, 8'h44);
        chk("frame1_y", y, 32'h44332211);
        chk("frame1_done", {31'd0, frame_done}, 32'd1);
        chk("frame1_cnt", {24'd0, frame_cnt}, 32'd1);

        // Words before any sof are ignored
        step(1, 0, 0, '0);
        step(0, 1, 0, 8'hAA);
        step(0, 1, 0, 8'hBB);
        chk("hunt_y", y, 32'h0);
        chk("hunt_locked", {31'd0, locked}, 32'd0);
        step(0, 1, 1, 8'hCC);
        chk("hunt_cap", y, 32'h000000CC);

        // Early sof
        step(1, 0, 0, '0);
        step(0, 1, 1, 8'h01);
        step(0, 1, 0, 8'h02);
        step(0, 1, 1, 8'h03);
        chk("early_sof_err", {31'd0, sync_err}, 32'd1);
        chk("early_sof_ch0", y, 32'h00000203);
        step(0, 1, 0, 8'h04);
        chk("early_sof_ch1", y, 32'h00000403);
        chk("early_sof_cnt", {24'd0, frame_cnt}, 32'd0);

        // Missing sof after a complete frame
        step(1, 0, 0, '0);
        frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        step(0, 1, 0, 8'h55);
        chk("miss_sof_err", {31'd0, sync_err}, 32'd1);
        chk("miss_sof_locked", {31'd0, locked}, 32'd0);
        chk("miss_sof_y", y, 32'h0D0C0B0A);

        // Gapped frame with sof held high on invalid cycles
        step(1, 0, 0, '0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, (k == 0), 8'(8'hE0 + k));
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(0, 0, 1, 8'($urandom));
        end
        chk("gap_y", y, 32'hE3E2E1E0);
        chk("gap_cnt", {24'd0, frame_cnt}, 32'd1);

        // Frame counter wrap, then reset mid-frame
        step(1, 0, 0, '0);
        for (int f = 0; f < 256; f++) frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        chk("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
        step(0, 1, 1, 8'h11);
        step(0, 1, 0, 8'h22);
        step(1, 1, 0, 8'h33);
        chk("midrst_y", y, 32'h0);
        chk("midrst_locked", {31'd0, locked}, 32'd0);
        frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        chk("post_rst_y", y, 32'hA4A3A2A1);

        // Random traffic: mostly well-formed, with gaps, stray sofs and rare resets
        for (int i = 0; i < 3000; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (m_locked && m_slot == 0) s = ($urandom_range(0, 7) != 0);
            else s = ($urandom_range(0, 9) == 0);
            step(r, v, s, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
